// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the 5-stage pipeline.
//   word_t      : 32-bit machine word
//   memstate_t  : MEM-stage request FSM states
//   WORD_OFF    : number of byte-offset bits below a word address
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_WAIT,
        MEM_HALTED
    } memstate_t;

    localparam int WORD_OFF = 2;

endpackage

// File: rtl/link_reg.sv
// ---------------------------------------------------------------------------
// link_reg
// Load-linked / store-conditional reservation register. Only compiled when
// the LLSC_EN macro is defined.
// Ports:
//   CLK, nRST    clock, asynchronous active-low reset
//   addr_i       address of the instruction currently in MEM
//   ll_done_i    an LL completed this cycle (capture addr_i)
//   st_done_i    a plain store completed this cycle
//   sc_done_i    an SC store completed this cycle (reservation consumed)
//   ccinv_i      coherence invalidate from the other core
//   snoop_i      invalidated address
//   sc_ok_o      an SC to addr_i may issue this cycle
// ---------------------------------------------------------------------------
`ifdef LLSC_EN
module link_reg
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] addr_i,
    input  logic              ll_done_i,
    input  logic              st_done_i,
    input  logic              sc_done_i,
    input  logic              ccinv_i,
    input  logic [WORD_W-1:0] snoop_i,
    output logic              sc_ok_o
);

    logic [WORD_W-1:WORD_OFF] link_addr_q, link_addr_d;
    logic                     link_valid_q, link_valid_d;
    logic                     addr_hit, inv_hit;
    logic                     unused_low;

    assign addr_hit = (link_addr_q == addr_i[WORD_W-1:WORD_OFF]);
    assign inv_hit  = ccinv_i & (snoop_i[WORD_W-1:WORD_OFF] == link_addr_q);

    // An invalidate landing in the same cycle as the SC wins: the SC fails.
    assign sc_ok_o  = link_valid_q & addr_hit & ~inv_hit;

    // Byte offsets never take part in reservation matching.
    assign unused_low = ^{addr_i[WORD_OFF-1:0], snoop_i[WORD_OFF-1:0]};

    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (inv_hit || (st_done_i && addr_hit) || sc_done_i) begin
            link_valid_d = 1'b0;
        end
        // A fresh LL re-arms the reservation even if an old one was dropped.
        if (ll_done_i) begin
            link_valid_d = 1'b1;
            link_addr_d  = addr_i[WORD_W-1:WORD_OFF];
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

endmodule
`endif

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Memory-access stage: issues one dcache request per load/store, stalls the
// pipeline until dhit, and produces the MEM/WB register. Define LLSC_EN to
// build the LL/SC reservation (link_reg); without it atomic_mem is ignored.
// Ports:
//   CLK, nRST                 clock, asynchronous active-low reset
//   *_mem                     EX/MEM register contents
//   dhit, dmemload            dcache completion and load data
//   ccinv, ccsnoopaddr        coherence invalidate
//   dmemREN/WEN/addr/store    dcache request
//   mem_stall                 freeze IF..MEM, bubble into WB
//   *_wb                      MEM/WB register contents (halt_wb is sticky)
// ---------------------------------------------------------------------------
module mem_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] ALUout_mem,
    input  logic [WORD_W-1:0] dmwdata_mem,
    input  logic              dREN_mem,
    input  logic              dWEN_mem,
    input  logic              atomic_mem,
    input  logic [REG_W-1:0]  regOut_mem,
    input  logic              rf_wen_mem,
    input  logic              MemtoReg_mem,
    input  logic              halt_mem,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    input  logic              ccinv,
    input  logic [WORD_W-1:0] ccsnoopaddr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic [WORD_W-1:0] rdata_wb,
    output logic [WORD_W-1:0] ALUout_wb,
    output logic [REG_W-1:0]  regOut_wb,
    output logic              rf_wen_wb,
    output logic              MemtoReg_wb,
    output logic              halt_wb
);

    memstate_t          state_q, state_d;
    logic [WORD_W-1:0]  rdata_q, alu_q;
    logic [REG_W-1:0]   reg_q;
    logic               rf_wen_q, m2r_q, halt_q;
    logic               is_load, is_store, is_sc, sc_fail;
    logic               req_active, req_done, stall_raw, halt_take;

    // dWEN wins when both request strobes are set.
    assign is_store = dWEN_mem;
    assign is_load  = dREN_mem & ~dWEN_mem;

`ifdef LLSC_EN
    logic sc_ok;

    assign is_sc = atomic_mem & dWEN_mem;

    link_reg #(.WORD_W(WORD_W)) u_link_reg (
        .CLK       (CLK),
        .nRST      (nRST),
        .addr_i    (ALUout_mem),
        .ll_done_i (req_done & is_load & atomic_mem),
        .st_done_i (req_done & is_store & ~atomic_mem),
        .sc_done_i (req_done & is_sc),
        .ccinv_i   (ccinv),
        .snoop_i   (ccsnoopaddr),
        .sc_ok_o   (sc_ok)
    );

    // The pass/fail decision is taken once, at issue; a store already in
    // flight is never withdrawn.
    assign sc_fail = is_sc & ~sc_ok & (state_q == MEM_IDLE);
`else
    logic unused_llsc;

    assign unused_llsc = ^{atomic_mem, ccinv, ccsnoopaddr};
    assign is_sc       = 1'b0;
    assign sc_fail     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        req_active = 1'b0;
        halt_take  = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                req_active = (is_load | is_store) & ~sc_fail;
                if (req_active && !dhit) begin
                    state_d = MEM_WAIT;
                end else if (halt_mem && !req_active) begin
                    halt_take = 1'b1;
                    state_d   = MEM_HALTED;
                end
            end
            MEM_WAIT: begin
                // Upstream is frozen by mem_stall, so the request fields hold.
                req_active = is_load | is_store;
                if (dhit) begin
                    state_d = MEM_IDLE;
                end
            end
            MEM_HALTED: begin
                state_d = MEM_HALTED;
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    assign req_done  = req_active & dhit;
    assign stall_raw = req_active & ~dhit;

    // Request outputs are forced low while reset is held.
    assign dmemREN   = nRST & req_active & is_load;
    assign dmemWEN   = nRST & req_active & is_store;
    assign mem_stall = nRST & stall_raw;
    assign dmemaddr  = {WORD_W{nRST}} & {ALUout_mem[WORD_W-1:WORD_OFF], {WORD_OFF{1'b0}}};
    assign dmemstore = {WORD_W{nRST}} & dmwdata_mem;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= MEM_IDLE;
            rdata_q  <= '0;
            alu_q    <= '0;
            reg_q    <= '0;
            rf_wen_q <= 1'b0;
            m2r_q    <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == MEM_HALTED || stall_raw) begin
                // Bubble into WB; halt_wb keeps its value.
                rf_wen_q <= 1'b0;
            end else begin
                alu_q    <= ALUout_mem;
                reg_q    <= regOut_mem;
                // An SC always writes its success flag back to rt.
                rf_wen_q <= rf_wen_mem | is_sc;
                m2r_q    <= MemtoReg_mem | is_sc;
                rdata_q  <= is_sc ? {{(WORD_W-1){1'b0}}, ~sc_fail} : dmemload;
                if (halt_take) begin
                    halt_q <= 1'b1;
                end
            end
        end
    end

    assign rdata_wb    = rdata_q;
    assign ALUout_wb   = alu_q;
    assign regOut_wb   = reg_q;
    assign rf_wen_wb   = rf_wen_q;
    assign MemtoReg_wb = m2r_q;
    assign halt_wb     = halt_q;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Directed bench for mem_stage. A cycle-level reference model of the stage
// (request/stall rules, MEM/WB contents, LL/SC reservation) is checked on
// every falling edge, plus hand-computed expectations per scenario.
// Builds with or without LLSC_EN.
// ---------------------------------------------------------------------------
module tb_mem_stage;
    import cpu_types_pkg::*;

`ifdef LLSC_EN
    localparam bit LLSC = 1'b1;
`else
    localparam bit LLSC = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    word_t       ALUout_mem, dmwdata_mem, dmemload, ccsnoopaddr;
    logic        dREN_mem, dWEN_mem, atomic_mem, rf_wen_mem, MemtoReg_mem, halt_mem;
    logic        dhit, ccinv;
    logic [4:0]  regOut_mem, regOut_wb;
    logic        dmemREN, dmemWEN, mem_stall, rf_wen_wb, MemtoReg_wb, halt_wb;
    word_t       dmemaddr, dmemstore, rdata_wb, ALUout_wb;

    int checks = 0;
    int errors = 0;

    mem_stage #(.WORD_W(32), .REG_W(5)) dut (
        .CLK(CLK), .nRST(nRST),
        .ALUout_mem(ALUout_mem), .dmwdata_mem(dmwdata_mem),
        .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .atomic_mem(atomic_mem),
        .regOut_mem(regOut_mem), .rf_wen_mem(rf_wen_mem),
        .MemtoReg_mem(MemtoReg_mem), .halt_mem(halt_mem),
        .dhit(dhit), .dmemload(dmemload),
        .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .mem_stall(mem_stall),
        .rdata_wb(rdata_wb), .ALUout_wb(ALUout_wb), .regOut_wb(regOut_wb),
        .rf_wen_wb(rf_wen_wb), .MemtoReg_wb(MemtoReg_wb), .halt_wb(halt_wb)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_busy = 0;   // request issued earlier, still awaiting dhit
    bit          m_halt = 0;
    bit          m_lv = 0;
    logic [29:0] m_la = '0;
    word_t       m_rdata = '0, m_alu = '0;
    logic [4:0]  m_reg = '0;
    bit          m_rfw = 0, m_m2r = 0;
    bit          m_known = 1;  // rdata_wb defined (loads, SC results, reset)

    function automatic bit model_sc();
        return LLSC && atomic_mem && dWEN_mem;
    endfunction

    function automatic bit model_link_ok();
        return m_lv && (ALUout_mem[31:2] == m_la) &&
               !(ccinv && (ccsnoopaddr[31:2] == m_la));
    endfunction

    function automatic bit model_issue();
        if (m_halt || !(dREN_mem || dWEN_mem)) return 1'b0;
        return m_busy || !model_sc() || model_link_ok();
    endfunction

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_busy = 0; m_halt = 0; m_lv = 0; m_la = '0;
            m_rdata = '0; m_alu = '0; m_reg = '0; m_rfw = 0; m_m2r = 0; m_known = 1;
        end else begin
            bit iss, sc, ld, st, done, lv_n;
            iss  = model_issue();
            sc   = model_sc();
            ld   = dREN_mem && !dWEN_mem;
            st   = dWEN_mem;
            done = iss && dhit;
            lv_n = m_lv && !(ccinv && (ccsnoopaddr[31:2] == m_la));
            if (LLSC && done) begin
                if (st && !atomic_mem && (ALUout_mem[31:2] == m_la)) lv_n = 0;
                if (sc) lv_n = 0;
                if (ld && atomic_mem) begin
                    lv_n = 1;
                    m_la = ALUout_mem[31:2];
                end
            end
            if (m_halt) begin
                m_rfw = 0;
            end else if (iss && !dhit) begin
                m_rfw  = 0;
                m_busy = 1;
            end else begin
                m_busy = 0;
                m_alu  = ALUout_mem;
                m_reg  = regOut_mem;
                m_rfw  = rf_wen_mem || sc;
                m_m2r  = MemtoReg_mem || sc;
                if (sc) begin
                    m_rdata = iss ? 32'd1 : 32'd0;
                    m_known = 1;
                end else if (ld) begin
                    m_rdata = dmemload;
                    m_known = 1;
                end else begin
                    m_known = 0;
                end
                if (halt_mem && !iss) m_halt = 1;
            end
            m_lv = lv_n;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge CLK) begin
        bit iss;
        iss = nRST && model_issue();
        chk("dmemREN", dmemREN, iss && dREN_mem && !dWEN_mem);
        chk("dmemWEN", dmemWEN, iss && dWEN_mem);
        chk("mem_stall", mem_stall, iss && !dhit);
        chk("dmemaddr", dmemaddr, nRST ? {ALUout_mem[31:2], 2'b00} : 32'd0);
        chk("dmemstore", dmemstore, nRST ? dmwdata_mem : 32'd0);
        chk("ALUout_wb", ALUout_wb, m_alu);
        chk("regOut_wb", regOut_wb, m_reg);
        chk("rf_wen_wb", rf_wen_wb, m_rfw);
        chk("MemtoReg_wb", MemtoReg_wb, m_m2r);
        chk("halt_wb", halt_wb, m_halt);
        if (m_known) chk("rdata_wb", rdata_wb, m_rdata);
    end

    // ---------------- stimulus ----------------
    int    st;
    word_t oa;
    bit    orn, own;

    // Presents one instruction; dhit arrives in cycle hit_after (-1: never).
    task automatic run_op(input string name, input bit ren, input bit wen, input bit at,
                          input word_t addr, input word_t wdata, input logic [4:0] rd,
                          input bit rfw, input bit m2r, input bit hlt, input int hit_after,
                          input word_t load_val);
        int last;
        dREN_mem = ren; dWEN_mem = wen; atomic_mem = at;
        ALUout_mem = addr; dmwdata_mem = wdata; regOut_mem = rd;
        rf_wen_mem = rfw; MemtoReg_mem = m2r; halt_mem = hlt;
        st = 0; oa = '0; orn = 0; own = 0;
        last = (hit_after < 0) ? 0 : hit_after;
        for (int c = 0; c <= last; c++) begin
            dhit = (hit_after >= 0) && (c == hit_after);
            dmemload = dhit ? load_val : (32'h0BAD0000 | c);
            #2;
            if (c == 0) begin
                oa = dmemaddr; orn = dmemREN; own = dmemWEN;
            end
            if (mem_stall) st++;
            @(posedge CLK); #1;
        end
        dhit = 0;
        $display("TXN %-8s addr=%h ren=%0d wen=%0d stalls=%0d rdata_wb=%h rf_wen_wb=%0d halt_wb=%0d",
                 name, oa, orn, own, st, rdata_wb, rf_wen_wb, halt_wb);
    endtask

    initial begin
        ALUout_mem = '0; dmwdata_mem = '0; dmemload = '0; ccsnoopaddr = '0;
        dREN_mem = 1; dWEN_mem = 0; atomic_mem = 0; regOut_mem = '0;
        rf_wen_mem = 0; MemtoReg_mem = 0; halt_mem = 0; dhit = 0; ccinv = 0;
        #1 nRST = 0;
        @(negedge CLK); #1;
        chk("rst_dmemREN", dmemREN, 0);
        chk("rst_rf_wen", rf_wen_wb, 0);
        chk("rst_halt", halt_wb, 0);
        chk("rst_rdata", rdata_wb, 0);
        @(posedge CLK); #1;
        nRST = 1; dREN_mem = 0;

        run_op("alu", 0, 0, 0, 32'h11, 0, 5'd3, 1, 0, 0, -1, 0);
        chk("alu_out", ALUout_wb, 32'h11);
        chk("alu_rd", regOut_wb, 5'd3);
        chk("alu_wen", rf_wen_wb, 1);

        run_op("lw", 1, 0, 0, 32'h104, 0, 5'd8, 1, 1, 0, 3, 32'hDEADBEEF);
        chk("lw_stalls", st, 3);
        chk("lw_addr", oa, 32'h104);
        chk("lw_ren", orn, 1);
        chk("lw_rdata", rdata_wb, 32'hDEADBEEF);
        chk("lw_wen", rf_wen_wb, 1);

        run_op("sw", 0, 1, 0, 32'h203, 32'h55, 5'd0, 0, 0, 0, 1, 0);
        chk("sw_addr", oa, 32'h200);
        chk("sw_wen", own, 1);
        chk("sw_stalls", st, 1);
        chk("sw_rfwen", rf_wen_wb, 0);

        run_op("ren_wen", 1, 1, 0, 32'h208, 32'h66, 5'd0, 0, 0, 0, 0, 0);
        chk("both_wen", own, 1);
        chk("both_ren", orn, 0);
        chk("both_stall", st, 0);

        run_op("ll", 1, 0, 1, 32'h300, 0, 5'd9, 1, 1, 0, 0, 32'h1234);
        run_op("sc", 0, 1, 1, 32'h300, 32'h77, 5'd10, 1, 1, 0, 1, 0);
        chk("sc1_wen", own, 1);
        chk("sc1_stalls", st, 1);
`ifdef LLSC_EN
        chk("sc1_rdata", rdata_wb, 1);
`endif
        run_op("sc_again", 0, 1, 1, 32'h300, 32'h78, 5'd10, 1, 1, 0, 0, 0);
`ifdef LLSC_EN
        chk("sc2_wen", own, 0);
        chk("sc2_stall", st, 0);
        chk("sc2_rdata", rdata_wb, 0);
        chk("sc2_rfwen", rf_wen_wb, 1);
        chk("sc2_m2r", MemtoReg_wb, 1);
`else
        chk("sc2_wen_plain", own, 1);
`endif

        // Invalidate of another byte in the same word kills the link.
        run_op("ll", 1, 0, 1, 32'h300, 0, 5'd9, 1, 1, 0, 0, 32'h1);
        ccinv = 1; ccsnoopaddr = 32'h302;
        run_op("alu_inv", 0, 0, 0, 32'h5, 0, 5'd1, 1, 0, 0, -1, 0);
        ccinv = 0;
        run_op("sc_inv", 0, 1, 1, 32'h300, 32'h79, 5'd10, 1, 1, 0, 0, 0);
`ifdef LLSC_EN
        chk("scinv_wen", own, 0);
        chk("scinv_rdata", rdata_wb, 0);
`endif

        // Invalidate of a different word leaves the link intact.
        run_op("ll", 1, 0, 1, 32'h300, 0, 5'd9, 1, 1, 0, 0, 32'h2);
        ccinv = 1; ccsnoopaddr = 32'h304;
        run_op("alu_inv2", 0, 0, 0, 32'h6, 0, 5'd1, 1, 0, 0, -1, 0);
        ccinv = 0;
        run_op("sc_ok", 0, 1, 1, 32'h300, 32'h7A, 5'd10, 1, 1, 0, 0, 0);
        chk("scok_wen", own, 1);
`ifdef LLSC_EN
        chk("scok_rdata", rdata_wb, 1);
`endif

        // Invalidate in the same cycle as the SC.
        run_op("ll", 1, 0, 1, 32'h300, 0, 5'd9, 1, 1, 0, 0, 32'h3);
        ccinv = 1; ccsnoopaddr = 32'h300;
        run_op("sc_race", 0, 1, 1, 32'h300, 32'h7B, 5'd10, 1, 1, 0, 0, 0);
        ccinv = 0;
`ifdef LLSC_EN
        chk("screace_wen", own, 0);
        chk("screace_rdata", rdata_wb, 0);
`endif

        // Plain store to the linked word drops the reservation.
        run_op("ll", 1, 0, 1, 32'h400, 0, 5'd9, 1, 1, 0, 0, 32'h4);
        run_op("sw", 0, 1, 0, 32'h400, 32'h99, 5'd0, 0, 0, 0, 0, 0);
        run_op("sc_st", 0, 1, 1, 32'h400, 32'h7C, 5'd10, 1, 1, 0, 0, 0);
`ifdef LLSC_EN
        chk("scst_wen", own, 0);
        chk("scst_rdata", rdata_wb, 0);
`endif

        // Reset while a load is waiting.
        run_op("ll", 1, 0, 1, 32'h500, 0, 5'd9, 1, 1, 0, 0, 32'h5);
        dREN_mem = 1; dWEN_mem = 0; atomic_mem = 0; ALUout_mem = 32'h504;
        rf_wen_mem = 1; MemtoReg_mem = 1; regOut_mem = 5'd7; dhit = 0;
        @(posedge CLK); #2;
        nRST = 0;
        #1;
        chk("rstw_ren", dmemREN, 0);
        chk("rstw_stall", mem_stall, 0);
        chk("rstw_addr", dmemaddr, 0);
        chk("rstw_alu", ALUout_wb, 0);
        chk("rstw_rfwen", rf_wen_wb, 0);
        $display("TXN reset   during wait, dmemREN=%0d mem_stall=%0d", dmemREN, mem_stall);
        @(posedge CLK); #1;
        nRST = 1; dREN_mem = 0;
        run_op("sc_rst", 0, 1, 1, 32'h500, 32'h7D, 5'd10, 1, 1, 0, 0, 0);
`ifdef LLSC_EN
        chk("scrst_wen", own, 0);
        chk("scrst_rdata", rdata_wb, 0);
`endif

        // Halt is sticky and blocks later requests.
        run_op("alu", 0, 0, 0, 32'h22, 0, 5'd4, 1, 0, 0, -1, 0);
        run_op("halt", 0, 0, 0, 32'h0, 0, 5'd0, 0, 0, 1, -1, 0);
        chk("halt_set", halt_wb, 1);
        run_op("lw_halt", 1, 0, 0, 32'h700, 0, 5'd2, 1, 1, 0, -1, 0);
        chk("halt_ren", orn, 0);
        chk("halt_stall", st, 0);
        chk("halt_rfwen", rf_wen_wb, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
        end
        chk("halt_sticky", halt_wb, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
